// File: rtl/snake_pkg.sv
// snake_pkg: shared constants, cell-type enum and helpers for the snake tile renderer.
//   GRID_W x GRID_H cells of 2^TILE_SHIFT pixels, default palette, address helper.
package snake_pkg;

  localparam int unsigned GRID_W     = 40;
  localparam int unsigned GRID_H     = 30;
  localparam int unsigned TILE_SHIFT = 4;
  localparam int unsigned CELL_COUNT = 1200;
  localparam int unsigned IDX_W      = 11;
  localparam int unsigned ROW_W      = 9;
  localparam int unsigned COL_W      = 10;
  localparam int unsigned X_W        = 6;
  localparam int unsigned Y_W        = 5;
  localparam int unsigned RGB_W      = 12;
  localparam int unsigned PIX_W      = 640;
  localparam int unsigned PIX_H      = 480;

  localparam logic [RGB_W-1:0] COL_EMPTY = 12'h000;
  localparam logic [RGB_W-1:0] COL_BODY  = 12'h0F0;
  localparam logic [RGB_W-1:0] COL_HEAD  = 12'h0A0;
  localparam logic [RGB_W-1:0] COL_FOOD  = 12'hF00;
  localparam logic [RGB_W-1:0] COL_GRID  = 12'h333;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BODY  = 2'd1,
    HEAD  = 2'd2,
    FOOD  = 2'd3
  } cell_t;

  // Cell colour lookup.
  function automatic logic [RGB_W-1:0] cell_colour(cell_t t);
    unique case (t)
      EMPTY:   return COL_EMPTY;
      BODY:    return COL_BODY;
      HEAD:    return COL_HEAD;
      FOOD:    return COL_FOOD;
      default: return COL_EMPTY;
    endcase
  endfunction

  // idx = y*40 + x, built from shifts so no multiplier is inferred.
  function automatic logic [IDX_W-1:0] cell_idx(logic [Y_W-1:0] y, logic [X_W-1:0] x);
    return (IDX_W'(y) << 5) + (IDX_W'(y) << 3) + IDX_W'(x);
  endfunction

endpackage

// File: rtl/snake_tile_renderer_if.sv
// snake_tile_renderer_if: ready/valid cell-write port from game logic.
//   wr_valid/wr_x/wr_y/wr_type driven by master, wr_ready driven by slave.
interface snake_tile_renderer_if;
  import snake_pkg::*;

  logic           wr_valid;
  logic           wr_ready;
  logic [X_W-1:0] wr_x;
  logic [Y_W-1:0] wr_y;
  cell_t          wr_type;

  modport master (output wr_valid, output wr_x, output wr_y, output wr_type, input wr_ready);
  modport slave  (input wr_valid, input wr_x, input wr_y, input wr_type, output wr_ready);

endinterface

// File: rtl/snake_tile_ram.sv
// snake_tile_ram: CELL_COUNT x 2-bit simple dual-port RAM, synchronous read-first.
//   clk; we/waddr/wdata write port; raddr/rdata registered read port. No reset.
module snake_tile_ram
  import snake_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  cell_t            wdata,
  input  logic [IDX_W-1:0] raddr,
  output cell_t            rdata
);

  cell_t mem [CELL_COUNT];

  // Both updates are non-blocking, so a same-address read sees the old value.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/snake_tile_renderer.sv
// snake_tile_renderer: 40x30 tile map feeding the VGA stage.
//   clk, rst (sync active-high); row/col/rdn read request -> Din two cycles later;
//   wr: ready/valid cell write port (slave); clear_req starts a map wipe, busy
//   flags it. Optional macro GRID_LINES_EN draws 12'h333 grid lines on EMPTY cells.
module snake_tile_renderer
  import snake_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ROW_W-1:0]       row,
  input  logic [COL_W-1:0]       col,
  input  logic                   rdn,
  output logic [RGB_W-1:0]       Din,
  snake_tile_renderer_if.slave   wr,
  input  logic                   clear_req,
  output logic                   busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             wr_ready_q;

  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  cell_t            ram_wdata;
  logic [IDX_W-1:0] ram_raddr;
  cell_t            ram_rdata;

  logic             rd_in_range;
  logic             wr_in_range;
  logic             s1_valid;
`ifdef GRID_LINES_EN
  logic             s1_grid;
`endif

  assign rd_in_range = (row < ROW_W'(PIX_H)) && (col < COL_W'(PIX_W));
  assign wr_in_range = (wr.wr_x < X_W'(GRID_W)) && (wr.wr_y < Y_W'(GRID_H));
  // Off-screen requests read cell 0 so the RAM is never indexed past its end.
  assign ram_raddr   = rd_in_range ? cell_idx(row[8:4], col[9:4]) : '0;
  assign wr.wr_ready = wr_ready_q;

  snake_tile_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Read pipeline stage 1 flags, stage 2 colour register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      Din      <= '0;
    end else begin
      s1_valid <= !rdn && rd_in_range;
      if (!s1_valid) begin
        Din <= '0;
      end else begin
        Din <= cell_colour(ram_rdata);
`ifdef GRID_LINES_EN
        if (ram_rdata == EMPTY && s1_grid) Din <= COL_GRID;
`endif
      end
    end
  end

`ifdef GRID_LINES_EN
  always_ff @(posedge clk) begin
    if (rst) s1_grid <= 1'b0;
    else     s1_grid <= (row[3:0] == 4'd0) || (col[3:0] == 4'd0);
  end
`endif

  // FSM state register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_ready_q <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ready_q <= (state_d == IDLE);
      busy       <= (state_d == CLEAR);
    end
  end

  // Next state and RAM write-port steering; the clear engine owns the port in CLEAR.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ram_we    = 1'b0;
    ram_waddr = cell_idx(wr.wr_y, wr.wr_x);
    ram_wdata = wr.wr_type;
    unique case (state_q)
      IDLE: begin
        // A write in the same cycle as clear_req still lands before the wipe.
        if (wr.wr_valid && wr_in_range) ram_we = 1'b1;
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        ram_wdata = EMPTY;
        cnt_d     = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(CELL_COUNT - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset mid-clear leaves the map exactly as far as the wipe got.
    if (rst) ram_we = 1'b0;
  end

endmodule

// File: doc/snake_tile_renderer.md
Name: snake_tile_renderer

Overview:
- Upstream pixel source for the VGA output stage. It holds the snake playfield as a tile map of 40x30 cells, each 16x16 pixels, covering 640x480.
- The game logic writes cell types through a ready/valid write port.
- The VGA stage reads colours by presenting row/col with rdn low. This block returns a 12-bit RGB word on Din with a fixed two-cycle latency.
- A built-in clear engine wipes the map to EMPTY on request.

Parameters:
- GRID_W, 40, cells per row (col[9:4] range)
- GRID_H, 30, cells per column (row[8:4] range)
- COL_EMPTY, 12'h000, colour of EMPTY cells
- COL_BODY, 12'h0F0, colour of BODY cells
- COL_HEAD, 12'h0A0, colour of HEAD cells
- COL_FOOD, 12'hF00, colour of FOOD cells

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst  in  1  synchronous active-high reset
- row  in  9  pixel row requested by VGA stage
- col  in  10  pixel column requested by VGA stage
- rdn  in  1  active-low read strobe from VGA stage
- Din  out  12  RGB 4:4:4 pixel to VGA stage
- wr_valid  in  1  game-logic write request
- wr_ready  out  1  write accepted when wr_valid and wr_ready are both high
- wr_x  in  6  cell column, 0..GRID_W-1
- wr_y  in  5  cell row, 0..GRID_H-1
- wr_type  in  2  cell type: 0 EMPTY, 1 BODY, 2 HEAD, 3 FOOD
- clear_req  in  1  single-cycle pulse; starts a full-map clear
- busy  out  1  high while a clear is in progress

Behaviour:
- Reset values: Din=0, wr_ready=1, busy=0, FSM=IDLE, pipeline valid bits=0. Tile RAM contents are not reset.
- Address: idx = row[8:4]*40 + col[9:4], computed as (r<<5)+(r<<3)+c. Width is 11 bits, range 0..1199.
- Read pipeline:
  - Cycle n: row, col and rdn are sampled; the RAM read address is registered; in-range and rdn flags go to stage 1.
  - Cycle n+1: RAM data is available; it is mapped to a colour and registered into Din.
  - Din is therefore valid at the start of cycle n+2.
  - If rdn=1, or row>=480, or col>=640 at cycle n, then Din=0 at n+2.
  - Back-to-back reads every cycle are supported.
- Write port:
  - The RAM is simple dual-port: one write port, one read port.
  - An accepted write updates the cell at the next clock edge.
  - Out-of-range wr_x (>=40) or wr_y (>=30) is accepted and dropped; no RAM write occurs.
  - A read and a write to the same address in the same cycle: the read returns the old value (read-first).
- FSM, states IDLE and CLEAR:
  - IDLE: wr_ready=1, busy=0. clear_req=1 → CLEAR with counter=0. clear_req and wr_valid high in the same cycle: the write is accepted first, then the clear starts.
  - CLEAR: wr_ready=0, busy=1. Writes EMPTY to idx=counter and increments counter every cycle. After writing idx 1199 → IDLE. The clear takes exactly 1200 cycles.
  - clear_req during CLEAR is ignored; there is no restart.
  - The read pipeline runs unaffected during CLEAR and returns whatever is currently stored.
- Reset mid-clear: FSM returns to IDLE and busy=0 on the next edge. Partially cleared contents are left as-is.

Optional Feature:
- Macro GRID_LINES_EN.
- Defined: on an EMPTY cell, pixels with row[3:0]==0 or col[3:0]==0 output 12'h333. Non-EMPTY cells are unaffected, and latency is unchanged.
- Undefined: EMPTY cells are uniformly COL_EMPTY, and no grid-line logic is synthesized.

Decomposition:
- Package snake_pkg holds:
  - cell-type enum (EMPTY/BODY/HEAD/FOOD, 2 bits)
  - GRID_W, GRID_H, TILE_SHIFT=4, CELL_COUNT=1200, IDX_W=11
  - default colour constants
- Sub-module snake_tile_ram: 1200x2 simple dual-port, synchronous read-first RAM, no reset, inferable as BRAM/LUTRAM.
- FSM, address arithmetic and colour mapping stay in the top module.

Test Plan:
- After reset, write (x=5, y=3, HEAD); then read row=48, col=80, rdn=0 → Din=12'h0A0 two cycles later, and 12'h000 for col=96.
- Hold rdn=1 with row=48, col=80 → Din=12'h000 at n+2. Set row=480, rdn=0 → Din=12'h000.
- Fill several cells with BODY, pulse clear_req:
  - busy is high for exactly 1200 cycles and wr_ready is low throughout.
  - a wr_valid during the clear is not accepted.
  - afterwards all reads return COL_EMPTY.
- Read and write of address (0,0) in the same cycle with FOOD → first read is the old colour; a read issued the following cycle returns 12'hF00.
- Assert rst at clear cycle 600 → busy=0 and wr_ready=1 on the next edge. Cells 0..599 read EMPTY; the prior contents of cell 1000 are preserved.
- With GRID_LINES_EN, read an EMPTY cell at row=32, col=37 → Din=12'h333. At row=33, col=37 → 12'h000.
